// File: rtl/vga_sched_pkg.sv
// Shared types and register addresses for the vga_ball write scheduler.
// Imported by the arbiter and the sequencer.
package vga_sched_pkg;

  localparam logic [2:0] ADDR_ATTR     = 3'd0;
  localparam logic [2:0] ADDR_SPR_PTR  = 3'd1;
  localparam logic [2:0] ADDR_SPR_DATA = 3'd2;

  typedef enum logic [2:0] {
    StIdle,
    StA0,
    StA1,
    StA2,
    StP0,
    StP1,
    StGap
  } sched_state_t;

  typedef enum logic {
    GntAttr,
    GntPat
  } grant_t;

endpackage

// File: rtl/vga_sprite_write_sched_if.sv
// Request channels and vga_ball register bus seen by the write scheduler.
// The scheduler uses the master view; command sources and the bench use the slave view.
interface vga_sprite_write_sched_if;
  logic       vblank;
  logic       attr_valid;
  logic       attr_ready;
  logic [7:0] attr_vpos;
  logic [7:0] attr_hpos;
  logic [7:0] attr_base;
  logic       pat_valid;
  logic       pat_ready;
  logic [7:0] pat_addr;
  logic [7:0] pat_data;
  logic       chipselect;
  logic       write;
  logic [2:0] address;
  logic [7:0] writedata;
  logic       busy;

  modport master (
    input  vblank, attr_valid, attr_vpos, attr_hpos, attr_base, pat_valid, pat_addr, pat_data,
    output attr_ready, pat_ready, chipselect, write, address, writedata, busy
  );

  modport slave (
    output vblank, attr_valid, attr_vpos, attr_hpos, attr_base, pat_valid, pat_addr, pat_data,
    input  attr_ready, pat_ready, chipselect, write, address, writedata, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the last winner loses the next tie.
// The history only advances when the caller reports an accepted grant.
module rr_arb2
  import vga_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_attr,
  input  logic req_pat,
  input  logic accept,
  output logic gnt_attr,
  output logic gnt_pat
);

  grant_t last_grant_q;

  always_comb begin
    gnt_attr = req_attr & (~req_pat | (last_grant_q == GntPat));
    gnt_pat  = req_pat & ~gnt_attr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GntPat;
    end else if (accept) begin
      last_grant_q <= gnt_attr ? GntAttr : GntPat;
    end
  end

endmodule

// File: rtl/vga_sprite_write_sched.sv
// Sequences sprite attribute (3 writes) and pattern (2 writes) transactions onto
// the vga_ball register port, with a fixed idle gap after every strobe.
module vga_sprite_write_sched
  import vga_sched_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
) (
  input logic                            clk,
  input logic                            reset,
  vga_sprite_write_sched_if.master       bus
);

  localparam logic [3:0] GapLast = 4'(GAP_CYCLES);

  sched_state_t state_q, state_d, ret_q, ret_d;
  logic [3:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]   vpos_q, hpos_q, base_q, paddr_q, pdata_q;
  logic [2:0]   addr_hold_q, strobe_addr;
  logic [7:0]   data_hold_q, strobe_data;
  logic         strobe, idle, gnt_attr, gnt_pat, accept;

  assign idle = (state_q == StIdle);

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_attr (idle & bus.attr_valid & bus.vblank),
    .req_pat  (idle & bus.pat_valid),
    .accept   (accept),
    .gnt_attr (gnt_attr),
    .gnt_pat  (gnt_pat)
  );

  assign bus.attr_ready = gnt_attr;
  assign bus.pat_ready  = gnt_pat;
  assign accept         = gnt_attr | gnt_pat;

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    gap_cnt_d   = gap_cnt_q;
    strobe      = 1'b0;
    strobe_addr = ADDR_ATTR;
    strobe_data = 8'h00;
    case (state_q)
      StIdle: begin
        if (gnt_attr)     state_d = StA0;
        else if (gnt_pat) state_d = StP0;
      end
      StA0, StA1, StA2, StP0, StP1: begin
        strobe    = 1'b1;
        state_d   = StGap;
        gap_cnt_d = 4'd1;
        case (state_q)
          StA0:    begin strobe_data = vpos_q; ret_d = StA1; end
          StA1:    begin strobe_data = hpos_q; ret_d = StA2; end
          StA2:    begin strobe_data = base_q; ret_d = StIdle; end
          StP0:    begin strobe_addr = ADDR_SPR_PTR;  strobe_data = paddr_q; ret_d = StP1; end
          default: begin strobe_addr = ADDR_SPR_DATA; strobe_data = pdata_q; ret_d = StIdle; end
        endcase
      end
      StGap: begin
        if (gap_cnt_q == GapLast) state_d = ret_q;
        else                      gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address/data are driven live during a strobe and held from the last strobe otherwise.
  assign bus.chipselect = strobe;
  assign bus.write      = strobe;
  assign bus.address    = strobe ? strobe_addr : addr_hold_q;
  assign bus.writedata  = strobe ? strobe_data : data_hold_q;
  assign bus.busy       = ~idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ret_q       <= StIdle;
      gap_cnt_q   <= 4'd0;
      vpos_q      <= 8'h00;
      hpos_q      <= 8'h00;
      base_q      <= 8'h00;
      paddr_q     <= 8'h00;
      pdata_q     <= 8'h00;
      addr_hold_q <= 3'd0;
      data_hold_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      gap_cnt_q <= gap_cnt_d;
      if (gnt_attr) begin
        vpos_q <= bus.attr_vpos;
        hpos_q <= bus.attr_hpos;
        base_q <= bus.attr_base;
      end
      if (gnt_pat) begin
        paddr_q <= bus.pat_addr;
        pdata_q <= bus.pat_data;
      end
      if (strobe) begin
        addr_hold_q <= strobe_addr;
        data_hold_q <= strobe_data;
      end
    end
  end

endmodule

// File: tb/tb_vga_sprite_write_sched.sv
// Directed self-checking bench for vga_sprite_write_sched with GAP_CYCLES = 2.
module tb_vga_sprite_write_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_sprite_write_sched_if bus ();

  vga_sprite_write_sched #(.GAP_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;
  int both_rdy = 0;
  logic [2:0] log_addr[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];

  always @(negedge clk) begin
    if (bus.chipselect && bus.write) begin
      log_addr.push_back(bus.address);
      log_data.push_back(bus.writedata);
      log_cyc.push_back(cyc);
    end
    if (bus.attr_ready && bus.pat_ready) both_rdy++;
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic wait_idle(output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.vblank = 1'b0; bus.attr_valid = 1'b0; bus.pat_valid = 1'b0;
    bus.attr_vpos = 8'h00; bus.attr_hpos = 8'h00; bus.attr_base = 8'h00;
    bus.pat_addr = 8'h00; bus.pat_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vecs++; if (bus.chipselect !== 1'b0) begin errs++; $display("FAIL reset_cs got %b want 0", bus.chipselect); end
    vecs++; if (bus.write !== 1'b0) begin errs++; $display("FAIL reset_wr got %b want 0", bus.write); end
    vecs++; if (bus.address !== 3'd0) begin errs++; $display("FAIL reset_addr got %h want 0", bus.address); end
    vecs++; if (bus.writedata !== 8'h00) begin errs++; $display("FAIL reset_data got %h want 00", bus.writedata); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vecs++; if (bus.attr_ready !== 1'b0 || bus.pat_ready !== 1'b0) begin
      errs++; $display("FAIL reset_ready got %b%b want 00", bus.attr_ready, bus.pat_ready);
    end
  endtask

  // Attribute transaction; optionally drops vblank one cycle after acceptance.
  task automatic run_attr(input logic [7:0] v, input logic [7:0] h, input logic [7:0] b,
                          input bit drop_vblank, input string name);
    logic [7:0] exp_d[3];
    int k, c;
    exp_d[0] = v; exp_d[1] = h; exp_d[2] = b;
    @(negedge clk);
    clear_log();
    bus.vblank = 1'b1; bus.attr_vpos = v; bus.attr_hpos = h; bus.attr_base = b;
    bus.attr_valid = 1'b1;
    #1;
    vecs++; if (bus.attr_ready !== 1'b1) begin errs++; $display("FAIL %s_ready got %b want 1", name, bus.attr_ready); end
    k = cyc;
    @(negedge clk);
    bus.attr_valid = 1'b0;
    if (drop_vblank) bus.vblank = 1'b0;
    wait_idle(c);
    vecs++; if (log_addr.size() !== 3) begin errs++; $display("FAIL %s_count got %0d want 3", name, log_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < log_addr.size()) begin
        vecs++;
        if (log_addr[i] !== 3'd0 || log_data[i] !== exp_d[i] || log_cyc[i] !== k + 1 + 3 * i) begin
          errs++;
          $display("FAIL %s_strobe%0d got a%0d/%h@%0d want a0/%h@%0d", name, i, log_addr[i],
                   log_data[i], log_cyc[i], exp_d[i], k + 1 + 3 * i);
        end
      end
    end
    vecs++; if (c !== k + 10) begin errs++; $display("FAIL %s_idle got %0d want %0d", name, c, k + 10); end
  endtask

  task automatic test_attr();
    run_attr(8'hC0, 8'hF1, 8'h02, 1'b0, "attr");
  endtask

  task automatic test_pattern();
    int k, c;
    @(negedge clk);
    clear_log();
    bus.pat_addr = 8'h05; bus.pat_data = 8'h33; bus.pat_valid = 1'b1;
    #1;
    vecs++; if (bus.pat_ready !== 1'b1) begin errs++; $display("FAIL pat_ready got %b want 1", bus.pat_ready); end
    k = cyc;
    @(negedge clk);
    bus.pat_valid = 1'b0;
    wait_idle(c);
    vecs++; if (log_addr.size() !== 2) begin errs++; $display("FAIL pat_count got %0d want 2", log_addr.size()); end
    if (log_addr.size() >= 2) begin
      vecs++;
      if (log_addr[0] !== 3'd1 || log_data[0] !== 8'h05 || log_cyc[0] !== k + 1) begin
        errs++; $display("FAIL pat_ptr got a%0d/%h@%0d want a1/05@%0d", log_addr[0], log_data[0], log_cyc[0], k + 1);
      end
      vecs++;
      if (log_addr[1] !== 3'd2 || log_data[1] !== 8'h33 || log_cyc[1] !== k + 4) begin
        errs++; $display("FAIL pat_data got a%0d/%h@%0d want a2/33@%0d", log_addr[1], log_data[1], log_cyc[1], k + 4);
      end
    end
    vecs++; if (c !== k + 7) begin errs++; $display("FAIL pat_idle got %0d want %0d", c, k + 7); end
    vecs++; if (bus.address !== 3'd2 || bus.writedata !== 8'h33) begin
      errs++; $display("FAIL pat_hold got %0d/%h want 2/33", bus.address, bus.writedata);
    end
  endtask

  task automatic test_vblank_gate();
    int rdy_seen = 0;
    int k, c;
    @(negedge clk);
    clear_log();
    bus.vblank = 1'b0; bus.attr_vpos = 8'h5A; bus.attr_hpos = 8'hA5; bus.attr_base = 8'h0F;
    bus.attr_valid = 1'b1;
    repeat (100) begin
      #1;
      if (bus.attr_ready) rdy_seen++;
      @(negedge clk);
    end
    vecs++; if (rdy_seen !== 0) begin errs++; $display("FAIL gate_ready got %0d want 0", rdy_seen); end
    vecs++; if (log_addr.size() !== 0) begin errs++; $display("FAIL gate_strobe got %0d want 0", log_addr.size()); end
    bus.vblank = 1'b1;
    #1;
    vecs++; if (bus.attr_ready !== 1'b1) begin errs++; $display("FAIL gate_accept got %b want 1", bus.attr_ready); end
    k = cyc;
    @(negedge clk);
    bus.attr_valid = 1'b0;
    wait_idle(c);
    vecs++; if (log_addr.size() !== 3 || log_cyc[0] !== k + 1) begin
      errs++; $display("FAIL gate_run got %0d strobes want 3 from %0d", log_addr.size(), k + 1);
    end
  endtask

  task automatic test_atomicity();
    run_attr(8'h11, 8'h22, 8'h44, 1'b1, "atomic");
  endtask

  task automatic test_contention();
    string order = "";
    int c;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    both_rdy = 0;
    bus.vblank = 1'b1; bus.attr_valid = 1'b1; bus.pat_valid = 1'b1;
    bus.attr_vpos = 8'h01; bus.attr_hpos = 8'h02; bus.attr_base = 8'h03;
    bus.pat_addr = 8'h10; bus.pat_data = 8'h20;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.attr_ready) order = {order, "A"};
      if (bus.pat_ready) order = {order, "P"};
      if (order.len() >= 4) break;
      @(negedge clk);
    end
    @(negedge clk);
    bus.attr_valid = 1'b0; bus.pat_valid = 1'b0;
    wait_idle(c);
    vecs++; if (order != "APAP") begin errs++; $display("FAIL rr_order got %s want APAP", order); end
    vecs++; if (both_rdy !== 0) begin errs++; $display("FAIL rr_both got %0d want 0", both_rdy); end
    vecs++; if (log_addr.size() !== 10) begin errs++; $display("FAIL rr_strobes got %0d want 10", log_addr.size()); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    clear_log();
    bus.vblank = 1'b1; bus.attr_vpos = 8'hAA; bus.attr_hpos = 8'hBB; bus.attr_base = 8'hCC;
    bus.attr_valid = 1'b1;
    @(negedge clk);
    bus.attr_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vecs++; if (bus.chipselect !== 1'b0 || bus.write !== 1'b0 || bus.busy !== 1'b0) begin
      errs++; $display("FAIL midrst_ctl got cs%b wr%b busy%b want 000", bus.chipselect, bus.write, bus.busy);
    end
    vecs++; if (bus.address !== 3'd0 || bus.writedata !== 8'h00) begin
      errs++; $display("FAIL midrst_bus got %0d/%h want 0/00", bus.address, bus.writedata);
    end
    repeat (12) @(negedge clk);
    vecs++; if (log_addr.size() !== 2) begin errs++; $display("FAIL midrst_strobes got %0d want 2", log_addr.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_attr();
    test_pattern();
    test_vblank_gate();
    test_atomicity();
    test_contention();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
